// File: rtl/vend_ctrl.sv
// vend_ctrl: top-level sequencer for the vending datapath.
//   Accumulates coin credit, accepts a product selection against a fixed
//   price table, drives the dispense mechanism through a req/ack handshake
//   with timeout, then pays out change one coin at a time via the hopper.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   coin[1:0]  coin event: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
//   sel_valid  one-cycle selection strobe, sel[1:0] = product index
//   cancel     one-cycle refund request
//   disp_ack   dispense mechanism finished
//   chg_ack    hopper ejected the requested coin
//   disp_req   dispense request (level), disp_id = product being dispensed
//   chg_req    change coin request (level), chg_coin = coin code to eject
//   credit     current credit in coin units
//   reject     pulse: coin presented last cycle was refused
//   insuf      pulse: selection refused for low credit
//   fault      pulse: disp_ack timed out
//   busy       high while vending or paying change
module vend_ctrl #(
  parameter int CW         = 4,
  parameter int MAX_CREDIT = 15,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 5,
  parameter int PRICE2     = 7,
  parameter int PRICE3     = 9,
  parameter int ACK_TO     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          sel_valid,
  input  logic [1:0]    sel,
  input  logic          cancel,
  input  logic          disp_ack,
  input  logic          chg_ack,
  output logic          disp_req,
  output logic [1:0]    disp_id,
  output logic          chg_req,
  output logic [1:0]    chg_coin,
  output logic [CW-1:0] credit,
  output logic          reject,
  output logic          insuf,
  output logic          fault,
  output logic          busy
);

  localparam int TW = $clog2(ACK_TO + 1);
  localparam logic [CW:0] MAX_W = (CW+1)'(MAX_CREDIT);
  localparam logic [4*CW-1:0] PRICE_VEC =
    {CW'(PRICE3), CW'(PRICE2), CW'(PRICE1), CW'(PRICE0)};

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_VEND, ST_CHANGE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           disp_req_q, disp_req_d;
  logic [1:0]     disp_id_q, disp_id_d;
  logic           chg_req_q, chg_req_d;
  logic [1:0]     chg_coin_q, chg_coin_d;
  logic           reject_q, reject_d;
  logic           insuf_q, insuf_d;
  logic           fault_q, fault_d;
  logic           busy_q, busy_d;

  logic [CW-1:0]  price_tbl [4];
  logic [CW-1:0]  price_sel;
  logic [CW:0]    coin_sum;
  logic [CW:0]    chg_val;
  logic [CW:0]    refund_sum;
  logic           accept_coin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_price
    assign price_tbl[gi] = PRICE_VEC[gi*CW +: CW];
  end

  function automatic logic [CW:0] coin_val(input logic [1:0] c);
    case (c)
      2'b01:   coin_val = (CW+1)'(1);
      2'b10:   coin_val = (CW+1)'(2);
      2'b11:   coin_val = (CW+1)'(5);
      default: coin_val = '0;
    endcase
  endfunction

  assign price_sel  = price_tbl[sel];
  assign coin_sum   = {1'b0, credit_q} + coin_val(coin);
  assign chg_val    = coin_val(chg_coin_q);
  assign refund_sum = {1'b0, credit_q} + {1'b0, price_tbl[disp_id_q]};

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    cnt_d       = cnt_q;
    disp_req_d  = disp_req_q;
    disp_id_d   = disp_id_q;
    chg_req_d   = chg_req_q;
    chg_coin_d  = chg_coin_q;
    reject_d    = 1'b0;
    insuf_d     = 1'b0;
    fault_d     = 1'b0;
    accept_coin = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Zero credit can never cover a price; cancel has nothing to refund.
        insuf_d     = sel_valid;
        accept_coin = 1'b1;
      end
      ST_CREDIT: begin
        if (cancel) begin
          state_d  = ST_CHANGE;
          reject_d = (coin != 2'b00);
        end else if (sel_valid && (credit_q >= price_sel)) begin
          credit_d   = credit_q - price_sel;
          disp_id_d  = sel;
          disp_req_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_VEND;
          reject_d   = (coin != 2'b00);
        end else begin
          insuf_d     = sel_valid;
          accept_coin = 1'b1;
        end
      end
      ST_VEND: begin
        reject_d = (coin != 2'b00);
        if (disp_ack) begin
          // Ack takes precedence over a timeout landing in the same cycle.
          disp_req_d = 1'b0;
          state_d    = ST_CHANGE;
        end else if (cnt_q == TW'(ACK_TO - 1)) begin
          fault_d    = 1'b1;
          disp_req_d = 1'b0;
          credit_d   = (refund_sum > MAX_W) ? CW'(MAX_CREDIT) : refund_sum[CW-1:0];
          state_d    = ST_CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHANGE: begin
        reject_d = (coin != 2'b00);
        if (chg_req_q) begin
          // Request drops for one cycle after each ack before re-evaluating.
          if (chg_ack) begin
            credit_d  = credit_q - chg_val[CW-1:0];
            chg_req_d = 1'b0;
          end
        end else if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          chg_req_d = 1'b1;
          if ({1'b0, credit_q} >= (CW+1)'(5))      chg_coin_d = 2'b11;
          else if ({1'b0, credit_q} >= (CW+1)'(2)) chg_coin_d = 2'b10;
          else                                     chg_coin_d = 2'b01;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_coin && (coin != 2'b00)) begin
      if (coin_sum <= MAX_W) begin
        credit_d = coin_sum[CW-1:0];
        state_d  = ST_CREDIT;
      end else begin
        reject_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      cnt_q      <= '0;
      disp_req_q <= 1'b0;
      disp_id_q  <= 2'b00;
      chg_req_q  <= 1'b0;
      chg_coin_q <= 2'b00;
      reject_q   <= 1'b0;
      insuf_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      cnt_q      <= cnt_d;
      disp_req_q <= disp_req_d;
      disp_id_q  <= disp_id_d;
      chg_req_q  <= chg_req_d;
      chg_coin_q <= chg_coin_d;
      reject_q   <= reject_d;
      insuf_q    <= insuf_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  assign disp_req = disp_req_q;
  assign disp_id  = disp_id_q;
  assign chg_req  = chg_req_q;
  assign chg_coin = chg_coin_q;
  assign credit   = credit_q;
  assign reject   = reject_q;
  assign insuf    = insuf_q;
  assign fault    = fault_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl. Inputs are driven and outputs sampled
// on the falling clock edge; every expected value is hand-computed.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic [1:0] chg_coin;
  logic [3:0] credit;
  logic       reject;
  logic       insuf;
  logic       fault;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  vend_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .coin     (coin),
    .sel_valid(sel_valid),
    .sel      (sel),
    .cancel   (cancel),
    .disp_ack (disp_ack),
    .chg_ack  (chg_ack),
    .disp_req (disp_req),
    .disp_id  (disp_id),
    .chg_req  (chg_req),
    .chg_coin (chg_coin),
    .credit   (credit),
    .reject   (reject),
    .insuf    (insuf),
    .fault    (fault),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    tick();
    coin = 2'b00;
    $display("[TB] coin %0d -> credit %0d reject %0d", c, credit, reject);
  endtask

  task automatic select(input logic [1:0] s);
    sel_valid = 1'b1;
    sel       = s;
    tick();
    sel_valid = 1'b0;
    $display("[TB] select %0d -> credit %0d disp_req %0d insuf %0d", s, credit, disp_req, insuf);
  endtask

  // Expects chg_req up with exp_coin, acks it, checks the one-cycle gap and
  // the remaining credit, then advances to the re-evaluation cycle.
  task automatic pay(input int exp_coin, input int exp_left);
    chk("chg_req_up", int'(chg_req), 1);
    chk("chg_coin", int'(chg_coin), exp_coin);
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    chk("chg_req_gap", int'(chg_req), 0);
    chk("chg_credit", int'(credit), exp_left);
    $display("[TB] change coin %0d paid -> credit %0d", exp_coin, credit);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; coin = 2'b00; sel_valid = 1'b0; sel = 2'b00;
    cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    tick(); tick();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_disp_req", int'(disp_req), 0);
    chk("rst_chg_req", int'(chg_req), 0);
    rst = 1'b0;
    tick();

    // Exact-price vend, no change due.
    put_coin(2'b10);
    chk("s1_credit2", int'(credit), 2);
    put_coin(2'b01);
    chk("s1_credit3", int'(credit), 3);
    chk("s1_busy_credit", int'(busy), 0);
    select(2'd0);
    chk("s1_disp_req", int'(disp_req), 1);
    chk("s1_disp_id", int'(disp_id), 0);
    chk("s1_credit0", int'(credit), 0);
    chk("s1_busy_vend", int'(busy), 1);
    repeat (3) tick();
    chk("s1_disp_hold", int'(disp_req), 1);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("s1_disp_drop", int'(disp_req), 0);
    chk("s1_busy_change", int'(busy), 1);
    tick();
    chk("s1_busy_idle", int'(busy), 0);
    chk("s1_no_chg", int'(chg_req), 0);

    // Vend with one 5-unit coin of change; chg_coin held while waiting.
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b10);
    chk("s2_credit12", int'(credit), 12);
    select(2'd2);
    chk("s2_credit5", int'(credit), 5);
    chk("s2_disp_id", int'(disp_id), 2);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("s2_chg_first_low", int'(chg_req), 0);
    tick();
    tick();
    chk("s2_chg_stable", int'(chg_coin), 3);
    pay(3, 0);
    chk("s2_idle", int'(busy), 0);

    // Insufficient credit, then cancel refund as two 2-unit coins.
    put_coin(2'b10); put_coin(2'b10);
    select(2'd1);
    chk("s3_insuf", int'(insuf), 1);
    chk("s3_credit4", int'(credit), 4);
    chk("s3_not_busy", int'(busy), 0);
    tick();
    chk("s3_insuf_pulse", int'(insuf), 0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("s3_cancel_busy", int'(busy), 1);
    chk("s3_cancel_credit", int'(credit), 4);
    tick();
    pay(2, 2);
    pay(2, 0);
    chk("s3_idle", int'(busy), 0);

    // Overflow reject, fill to max, coin during vend rejected.
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b10); put_coin(2'b10);
    chk("s4_credit14", int'(credit), 14);
    put_coin(2'b10);
    chk("s4_reject", int'(reject), 1);
    chk("s4_credit_kept", int'(credit), 14);
    put_coin(2'b01);
    chk("s4_credit15", int'(credit), 15);
    chk("s4_reject_clear", int'(reject), 0);
    select(2'd3);
    chk("s4_credit6", int'(credit), 6);
    put_coin(2'b01);
    chk("s4_vend_reject", int'(reject), 1);
    chk("s4_vend_credit", int'(credit), 6);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    // Stray ack while chg_req is low must not take credit.
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    chk("s4_stray_ack_credit", int'(credit), 6);
    pay(3, 1);
    pay(1, 0);
    chk("s4_idle", int'(busy), 0);

    // Dispense timeout: fault, refund, change paid 5+2+2.
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b10);
    chk("s5_credit9", int'(credit), 9);
    select(2'd3);
    chk("s5_credit0", int'(credit), 0);
    n = 0;
    while (!fault && n < 400) begin
      tick();
      n++;
    end
    $display("[TB] timeout after %0d cycles", n);
    chk("s5_timeout_cycles", n, 255);
    chk("s5_refund", int'(credit), 9);
    chk("s5_disp_drop", int'(disp_req), 0);
    tick();
    chk("s5_fault_pulse", int'(fault), 0);
    pay(3, 4);
    pay(2, 2);
    pay(2, 0);
    chk("s5_idle", int'(busy), 0);

    // Cancel beats select and coin; async reset mid-handshake.
    put_coin(2'b11); put_coin(2'b01);
    chk("s6_credit6", int'(credit), 6);
    cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0; coin = 2'b11;
    tick();
    cancel = 1'b0; sel_valid = 1'b0; coin = 2'b00;
    chk("s6_busy", int'(busy), 1);
    chk("s6_credit", int'(credit), 6);
    chk("s6_reject", int'(reject), 1);
    chk("s6_no_disp", int'(disp_req), 0);
    tick();
    chk("s6_chg_req", int'(chg_req), 1);
    rst = 1'b1;
    #1;
    chk("s6_rst_chg_req", int'(chg_req), 0);
    chk("s6_rst_chg_coin", int'(chg_coin), 0);
    chk("s6_rst_credit", int'(credit), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_reject", int'(reject), 0);
    $display("[TB] async reset during change request");
    tick();
    rst = 1'b0;
    tick();
    chk("s6_post_busy", int'(busy), 0);
    put_coin(2'b01);
    chk("s6_post_credit", int'(credit), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Top-level sequencer for the vending datapath.
- Accumulates coin credit from the 2-bit coin code bus and accepts a product selection against a price table.
- Drives the dispense mechanism through a req/ack handshake with timeout, then pays out change one coin at a time through a second req/ack handshake.
- Sits between the coin acceptor / keypad and the dispense motor and change hopper.

Parameters:
- CW, 4, credit register width in coin units.
- MAX_CREDIT, 15, highest credit held; must be ≤ 2^CW−1.
- PRICE0, 3, price of product 0 in units.
- PRICE1, 5, price of product 1.
- PRICE2, 7, price of product 2.
- PRICE3, 9, price of product 3.
- ACK_TO, 255, cycles to wait for disp_ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- coin  in  2  coin code, one-cycle event per coin: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- sel_valid  in  1  one-cycle selection strobe.
- sel  in  2  product index, valid with sel_valid.
- cancel  in  1  one-cycle refund request.
- disp_ack  in  1  mechanism finished dispensing.
- chg_ack  in  1  hopper ejected the requested coin.
- disp_req  out  1  dispense request, level.
- disp_id  out  2  product being dispensed.
- chg_req  out  1  change coin request, level.
- chg_coin  out  2  coin code to eject (01/10/11).
- credit  out  CW  current credit.
- reject  out  1  one-cycle pulse: the coin presented last cycle was refused.
- insuf  out  1  one-cycle pulse: the selection was refused for low credit.
- fault  out  1  one-cycle pulse: disp_ack timed out.
- busy  out  1  high in VEND and CHANGE.

Behaviour:
- All outputs are registered.
- Reset (async, rst=1) forces state IDLE, credit=0, timeout counter=0, and every output 0.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0, accepting coins and selections.
  - VEND: waiting for disp_ack.
  - CHANGE: paying out change.
- Coin accept (IDLE/CREDIT):
  - If credit+value ≤ MAX_CREDIT, credit updates next cycle and the state goes to CREDIT.
  - Otherwise credit is unchanged and reject=1 next cycle.
- Coins in VEND or CHANGE: always reject, credit unchanged.
- Priority within one cycle in CREDIT: cancel > sel_valid > coin.
  - cancel: go to CHANGE, credit kept; any coin that cycle is rejected, sel ignored.
  - sel_valid with credit ≥ PRICE[sel]: credit −= PRICE[sel], disp_id=sel, disp_req=1 next cycle, go to VEND. A coin in the same cycle is rejected.
  - sel_valid with credit < PRICE[sel]: insuf=1 next cycle, stay in CREDIT. A coin in the same cycle is processed normally.
- Selection and cancel in IDLE: sel_valid produces an insuf pulse; cancel is ignored.
- VEND:
  - disp_req stays high until disp_ack is sampled. Then disp_req=0 and the state goes to CHANGE next cycle.
  - The timeout counter is cleared on VEND entry and increments every cycle.
  - If ACK_TO cycles elapse without disp_ack: fault=1 pulse, disp_req=0, credit += PRICE[disp_id] (refund, saturating at MAX_CREDIT), go to CHANGE.
  - disp_ack and timeout in the same cycle: the ack wins.
  - sel and cancel are ignored in VEND.
- CHANGE:
  - If credit==0, go to IDLE next cycle with chg_req=0.
  - Otherwise assert chg_req with a greedy coin: 11 if credit ≥ 5, else 10 if credit ≥ 2, else 01.
  - On sampled chg_ack: credit −= coin value, and chg_req=0 for exactly one cycle before re-evaluating.
  - chg_coin is stable while chg_req=1.
  - chg_ack while chg_req=0 is ignored.
- disp_ack outside VEND is ignored.
- busy=1 exactly when the state is VEND or CHANGE.
- Reset mid-handshake drops disp_req/chg_req immediately (async) and loses credit.

Test Plan:
- Coins 10, 01 (credit 3), sel_valid sel=0 → disp_req=1, disp_id=0, credit=0; disp_ack after 4 cycles → CHANGE, then IDLE with no chg_req, busy low.
- Coins 11, 11, 10 (credit 12), sel=2 (price 7) → credit 5, VEND; after ack, chg_req with chg_coin=11 and credit 0 after chg_ack; IDLE.
- Credit 4, sel=1 → insuf pulse, credit 4, state CREDIT; cancel → chg_coin 10, ack, one-cycle gap, 10, ack → credit 0, IDLE.
- Credit 14, coin 10 → reject pulse, credit 14; coin 01 → credit 15; coin during VEND → reject.
- Credit 9, sel=3, no disp_ack for 255 cycles → fault pulse, credit 9, change paid as 11, 10, 10.
- Same-cycle cancel+sel+coin 11 at credit 6 → CHANGE with credit 6, reject pulse; assert rst while chg_req=1 → all outputs 0 immediately, IDLE.
